// File: rtl/piece_sequencer_if.sv
// Bundle of piece_sequencer signals: generator handshake, spawn/hold requests, delivery and preview.
interface piece_sequencer_if #(
    parameter int unsigned PREVIEW_DEPTH = 3
);
    logic [2:0]                 rand_idx;
    logic                       new_block;
    logic                       spawn_req;
    logic                       hold_req;
    logic                       piece_valid;
    logic [2:0]                 piece_idx;
    logic [3*PREVIEW_DEPTH-1:0] preview;
    logic                       hold_valid;
    logic [2:0]                 hold_idx;
    logic                       queue_ready;

    modport master (
        output rand_idx, spawn_req, hold_req,
        input  new_block, piece_valid, piece_idx, preview, hold_valid, hold_idx, queue_ready
    );

    modport slave (
        input  rand_idx, spawn_req, hold_req,
        output new_block, piece_valid, piece_idx, preview, hold_valid, hold_idx, queue_ready
    );
endinterface

// File: rtl/piece_sequencer.sv
// 7-bag piece queue with preview window and delivery handshake.
// Define PIECE_HOLD_EN to build the hold/swap slot; otherwise hold_req is ignored.
module piece_sequencer #(
    parameter int unsigned PREVIEW_DEPTH = 3
) (
    input  logic             Clk,
    input  logic             Reset,
    piece_sequencer_if.slave bus
);
    localparam int unsigned QUEUE_DEPTH = PREVIEW_DEPTH + 1;
    localparam int unsigned CNT_W       = $clog2(QUEUE_DEPTH + 1);
    localparam int unsigned PW          = 3;
    localparam int unsigned BAG_W       = 7;

    typedef enum logic {S_FILL, S_READY} state_t;

    state_t            r_state, w_state_nxt;
    logic [PW-1:0]     r_queue     [QUEUE_DEPTH];
    logic [PW-1:0]     w_queue_nxt [QUEUE_DEPTH];
    logic [CNT_W-1:0]  r_count, w_count_nxt;
    logic [BAG_W-1:0]  r_bag, w_bag_nxt;
    logic              r_piece_valid, w_piece_valid_nxt;
    logic [PW-1:0]     r_piece_idx, w_piece_idx_nxt;
    logic              r_active, w_active_nxt;
    logic              w_deliver;

    logic [BAG_W:0]    w_bag_ext;
    logic [PW-1:0]     w_pick;
    logic [BAG_W-1:0]  w_bag_set;
    logic [BAG_W-1:0]  w_bag_after;

`ifdef PIECE_HOLD_EN
    logic              r_hold_valid, w_hold_valid_nxt;
    logic [PW-1:0]     r_hold_idx, w_hold_idx_nxt;
    logic              r_hold_lock, w_hold_lock_nxt;
`endif

    // Index 7 ("no piece") is treated as an always-taken bag slot so it falls back to the lowest free piece.
    assign w_bag_ext = {1'b1, r_bag};

    always_comb begin
        w_pick = bus.rand_idx;
        if (w_bag_ext[bus.rand_idx]) begin
            w_pick = '0;
            for (int i = int'(BAG_W) - 1; i >= 0; i--) begin
                if (!r_bag[i]) w_pick = PW'(i);
            end
        end
    end

    // A completed bag clears in the same cycle so the next append starts fresh.
    assign w_bag_set   = r_bag | (BAG_W'(1) << w_pick);
    assign w_bag_after = (&w_bag_set) ? '0 : w_bag_set;

    always_comb begin
        w_state_nxt       = r_state;
        w_queue_nxt       = r_queue;
        w_count_nxt       = r_count;
        w_bag_nxt         = r_bag;
        w_piece_valid_nxt = 1'b0;
        w_piece_idx_nxt   = r_piece_idx;
        w_active_nxt      = r_active;
        w_deliver         = 1'b0;
`ifdef PIECE_HOLD_EN
        w_hold_valid_nxt  = r_hold_valid;
        w_hold_idx_nxt    = r_hold_idx;
        w_hold_lock_nxt   = r_hold_lock;
`endif

        case (r_state)
            S_FILL: begin
                for (int i = 0; i < int'(QUEUE_DEPTH); i++) begin
                    if (r_count == CNT_W'(i)) w_queue_nxt[i] = w_pick;
                end
                w_count_nxt = r_count + CNT_W'(1);
                w_bag_nxt   = w_bag_after;
                if (r_count == CNT_W'(QUEUE_DEPTH - 1)) w_state_nxt = S_READY;
            end
            S_READY: begin
                if (bus.spawn_req) begin
                    w_deliver = 1'b1;
`ifdef PIECE_HOLD_EN
                    w_hold_lock_nxt = 1'b0;
`endif
                end
`ifdef PIECE_HOLD_EN
                else if (bus.hold_req && r_active && !r_hold_lock) begin
                    w_hold_lock_nxt = 1'b1;
                    w_hold_idx_nxt  = r_piece_idx;
                    if (!r_hold_valid) begin
                        // Empty slot: stash the active piece and pull the next one from the queue.
                        w_hold_valid_nxt = 1'b1;
                        w_deliver        = 1'b1;
                    end else begin
                        w_piece_idx_nxt   = r_hold_idx;
                        w_piece_valid_nxt = 1'b1;
                    end
                end
`endif
            end
            default: w_state_nxt = S_FILL;
        endcase

        // Queue-head delivery shifts the queue and reopens filling.
        if (w_deliver) begin
            w_piece_valid_nxt = 1'b1;
            w_piece_idx_nxt   = r_queue[0];
            w_active_nxt      = 1'b1;
            for (int i = 0; i < int'(QUEUE_DEPTH) - 1; i++) begin
                w_queue_nxt[i] = r_queue[i+1];
            end
            w_queue_nxt[QUEUE_DEPTH-1] = '0;
            w_count_nxt = r_count - CNT_W'(1);
            w_state_nxt = S_FILL;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state       <= S_FILL;
            for (int i = 0; i < int'(QUEUE_DEPTH); i++) r_queue[i] <= '0;
            r_count       <= '0;
            r_bag         <= '0;
            r_piece_valid <= 1'b0;
            r_piece_idx   <= '0;
            r_active      <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_queue       <= w_queue_nxt;
            r_count       <= w_count_nxt;
            r_bag         <= w_bag_nxt;
            r_piece_valid <= w_piece_valid_nxt;
            r_piece_idx   <= w_piece_idx_nxt;
            r_active      <= w_active_nxt;
        end
    end

`ifdef PIECE_HOLD_EN
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_hold_valid <= 1'b0;
            r_hold_idx   <= '0;
            r_hold_lock  <= 1'b0;
        end else begin
            r_hold_valid <= w_hold_valid_nxt;
            r_hold_idx   <= w_hold_idx_nxt;
            r_hold_lock  <= w_hold_lock_nxt;
        end
    end

    assign bus.hold_valid = r_hold_valid;
    assign bus.hold_idx   = r_hold_idx;
`else
    logic w_unused_hold;
    assign w_unused_hold  = bus.hold_req ^ r_active;
    assign bus.hold_valid = 1'b0;
    assign bus.hold_idx   = '0;
`endif

    // Draw strobe must drop immediately while Reset is held, so it is gated by Reset directly.
    assign bus.new_block   = (r_state == S_FILL) && !Reset;
    assign bus.queue_ready = (r_state == S_READY);
    assign bus.piece_valid = r_piece_valid;
    assign bus.piece_idx   = r_piece_idx;

    always_comb begin
        bus.preview = '0;
        for (int i = 0; i < int'(PREVIEW_DEPTH); i++) begin
            bus.preview[PW*i +: PW] = r_queue[i];
        end
    end

endmodule

// File: doc/piece_sequencer.md
PIECE_SEQUENCER -- requirements
Module: piece_sequencer

Interface
REQ-001 SHALL have parameter PREVIEW_DEPTH, default 3, giving the number of preview entries (1..6); queue depth = PREVIEW_DEPTH+1.
REQ-002 SHALL have port Clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-003 SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port rand_idx, input, 3 bits: pseudo-random piece index from the generator; value 7 is legal and means "no piece".
REQ-005 SHALL have port new_block, output, 1 bit: draw strobe to the generator.
REQ-006 SHALL have port spawn_req, input, 1 bit: level request for next piece, held until piece_valid.
REQ-007 SHALL have port hold_req, input, 1 bit: single-cycle hold/swap request.
REQ-008 SHALL have port piece_valid, output, 1 bit: one-cycle delivery pulse.
REQ-009 SHALL have port piece_idx, output, 3 bits: active piece, updated with piece_valid and held until next delivery.
REQ-010 SHALL have port preview, output, 3*PREVIEW_DEPTH bits: upcoming pieces, bits [2:0] = next piece.
REQ-011 SHALL have port hold_valid, output, 1 bit, and port hold_idx, output, 3 bits: occupancy and content of the hold slot.
REQ-012 SHALL have port queue_ready, output, 1 bit: high when state is READY.

Function
REQ-013 SHALL implement states FILL and READY; FILL -> READY when queue holds PREVIEW_DEPTH+1 entries; READY -> FILL on any delivery.
REQ-014 In FILL, SHALL append exactly one entry per cycle and assert new_block in that same cycle; new_block SHALL be low in READY.
REQ-015 SHALL track a 7-bit bag mask of pieces already appended in the current bag.
REQ-016 Appended value SHALL be rand_idx if rand_idx<7 and its bag bit is clear; otherwise SHALL be the lowest-numbered piece whose bag bit is clear.
REQ-017 When an append sets the seventh bag bit, SHALL clear the mask in the same cycle, so the next append starts a fresh bag.
REQ-018 spawn_req high in READY at cycle t SHALL produce piece_valid at t+1 with piece_idx = queue head, queue shifted by one, state FILL.
REQ-019 spawn_req in FILL SHALL be held off: no delivery until READY.
REQ-020 hold_req in READY, when a piece is active and unlocked and the hold slot is empty, SHALL move piece_idx to the hold slot and deliver the queue head as in REQ-018.
REQ-021 hold_req in READY, when a piece is active and unlocked and the hold slot is full, SHALL swap piece_idx and hold_idx, pulse piece_valid at t+1, and leave the queue and state unchanged.
REQ-022 Any hold SHALL set hold_lock; a spawn_req delivery SHALL clear hold_lock.
REQ-023 hold_req SHALL be ignored in FILL, while hold_lock is set, or before the first delivery.
REQ-024 spawn_req and hold_req in the same READY cycle: spawn SHALL be served and hold ignored.

Reset
REQ-025 Reset SHALL empty the queue, clear the bag mask, hold_lock and active flag, and set state FILL.
REQ-026 Reset SHALL drive piece_valid=0, piece_idx=0, preview=0, hold_valid=0, hold_idx=0, queue_ready=0, new_block=0.
REQ-027 Reset asserted mid-fill or mid-delivery SHALL abandon the operation; no piece_valid SHALL follow.
REQ-028 The first cycle with Reset low SHALL be fill cycle 1; with PREVIEW_DEPTH=3, queue_ready SHALL be high in cycle 5.

Configuration
REQ-029 With macro PIECE_HOLD_EN defined, hold logic per REQ-020..REQ-024 SHALL be present.
REQ-030 Without PIECE_HOLD_EN, SHALL omit hold storage, ignore hold_req, and tie hold_valid=0 and hold_idx=0.

Verification
REQ-031 rand_idx constant 7, repeated spawns -> piece_idx sequence 0,1,2,3,4,5,6,0,1, ...
REQ-032 rand_idx constant 3 -> first bag delivered as 3,0,1,2,4,5,6; second bag begins with 3.
REQ-033 spawn_req raised in READY at cycle t -> piece_valid at t+1, queue_ready low at t+1, high again at t+2.
REQ-034 PIECE_HOLD_EN, active=2, hold empty, hold_req -> hold_idx=2, new piece delivered; a second hold_req before the next spawn is ignored; after a spawn, hold_req swaps the pieces.
REQ-035 Reset asserted in fill cycle 2 -> all outputs 0 next cycle, bag cleared, refill restarts and queue_ready is high 4 cycles after release.
REQ-036 spawn_req and hold_req in the same READY cycle -> one spawn delivery, hold_valid unchanged.
